uart_tx_serializer: RTL and testbench

UART transmit serializer for the system's UART link, the transmit-direction counterpart of the receive path's oversampling and data sampling logic. It accepts a parallel data word with a single-cycle valid strobe and emits one asynchronous serial frame on `TX_OUT`: a start bit, the data bits LSB first, an optional parity bit and a stop bit. `CLK` is the TX baud clock, so the block drives one serial bit per `CLK` cycle. The block sits between the system controller's TX FIFO read side and the UART pad.

---
 rtl/uart_tx_serializer_if.sv | 40 ++++
 rtl/uart_tx_serializer.sv | 119 +++++++++++
 tb/tb_uart_tx_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if
//   Groups the parallel request side and the serial line side of the UART
//   transmit serializer. The controller (FIFO read side) drives the request
//   signals through the master modport. The serializer drives TX_OUT/busy
//   through the slave modport.
//
//   P_DATA      controller -> serializer  word to transmit
//   Data_Valid  controller -> serializer  request strobe, honoured only when idle
//   PAR_EN      controller -> serializer  1 = append a parity bit
//   PAR_TYP     controller -> serializer  0 = even, 1 = odd parity
//   TX_OUT      serializer -> pad         registered serial line, idles high
//   busy        serializer -> controller  registered, high start..stop bit
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serializes one parallel word per request into an asynchronous UART frame:
//   start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, and
//   stop bit (1). CLK is the baud clock, so one serial bit is sent per cycle.
//
//   CLK   baud clock
//   RST   asynchronous active-high reset; aborts any frame in progress
//   bus   uart_tx_serializer_if.slave (P_DATA, Data_Valid, PAR_EN, PAR_TYP in;
//         TX_OUT, busy out)
//
//   state  | meaning
//   IDLE   | line high, not busy, waiting for Data_Valid
//   START  | driving the start bit (0)
//   DATA   | driving latched data bit[cnt], LSB first
//   PARITY | driving the parity bit of the latched word
//   STOP   | driving the stop bit (1); Data_Valid is not sampled here
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  uart_tx_serializer_if.slave     bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q,      tx_d;
  logic                  busy_q,    busy_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic. The frame configuration is captured only on the
  // accepting edge so the upstream side may change its inputs afterwards.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;

    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so TX_OUT and busy come straight from
  // flops. In DATA, cnt_d already points at the bit for the coming cycle, and
  // data_q is stable because it was latched one edge before DATA is entered.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;

    case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = data_q[cnt_d];
      PARITY:  tx_d   = (^data_q) ^ par_typ_q;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of line bits still owed for the current frame.
  bit mq[$];
  bit m_tx   = 1'b1;
  bit m_busy = 1'b0;

  // Observation capture for directed frames.
  bit obs[$];
  int busy_cnt;

  function automatic void build_frame(input logic [DW-1:0] w, input bit pe, input bit pt);
    int ones;
    mq.delete();
    mq.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      mq.push_back(w[i]);
      if (w[i]) ones++;
    end
    // Even parity makes the total count of ones even; odd makes it odd.
    if (pe) mq.push_back(bit'(ones % 2) ^ pt);
    mq.push_back(1'b1);
  endfunction

  task automatic check_line(input string tag);
    n_assert++;
    assert (bus.TX_OUT === m_tx) else begin
      n_fail++;
      $error("FAIL %s TX_OUT: observed %b expected %b", tag, bus.TX_OUT, m_tx);
    end
    n_assert++;
    assert (bus.busy === m_busy) else begin
      n_fail++;
      $error("FAIL %s busy: observed %b expected %b", tag, bus.busy, m_busy);
    end
  endtask

  // One baud cycle: update the model at the rising edge from the inputs the
  // DUT sees, then compare at the falling edge.
  task automatic tick(input string tag);
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      // A new frame needs an idle cycle after the previous stop bit.
      if (mq.size() == 0 && !m_busy && bus.Data_Valid === 1'b1)
        build_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
      if (mq.size() > 0) begin
        m_tx   = mq.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
    @(negedge CLK);
    check_line(tag);
    if (bus.busy === 1'b1) begin
      obs.push_back(bus.TX_OUT);
      busy_cnt++;
    end
  endtask

  task automatic randomize_inputs();
    bus.P_DATA  = DW'($urandom);
    bus.PAR_EN  = 1'($urandom);
    bus.PAR_TYP = 1'($urandom);
  endtask

  // Request one frame, then scramble inputs for the rest of it.
  task automatic send_frame(input logic [DW-1:0] w, input bit pe, input bit pt, input string tag);
    obs.delete();
    busy_cnt = 0;
    bus.P_DATA     = w;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    tick(tag);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      randomize_inputs();
      tick(tag);
    end
  endtask

  function automatic logic [15:0] pack_obs();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < obs.size() && i < 16; i++) v[i] = obs[i];
    return v;
  endfunction

  initial begin
    logic [15:0] seq;

    // Reset with random inputs.
    RST = 1'b1;
    bus.Data_Valid = 1'($urandom);
    randomize_inputs();
    #1;
    check_line("reset_async");
    for (int i = 0; i < 3; i++) begin
      bus.Data_Valid = 1'($urandom);
      randomize_inputs();
      tick("reset_hold");
    end
    RST = 1'b0;
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick("reset_idle");
    end

    // 0xA5 without parity.
    send_frame(8'hA5, 1'b0, 1'b0, "a5_nopar");
    seq = pack_obs();
    n_assert++;
    assert (seq === 16'h034A) else begin
      n_fail++;
      $error("FAIL a5_nopar_seq: observed %h expected 034a", seq);
    end
    n_assert++;
    assert (busy_cnt === 10) else begin
      n_fail++;
      $error("FAIL a5_nopar_busy: observed %0d expected 10", busy_cnt);
    end

    // 0xA5 even parity.
    send_frame(8'hA5, 1'b1, 1'b0, "a5_even");
    n_assert++;
    assert (obs.size() == 11 && obs[9] === 1'b0) else begin
      n_fail++;
      $error("FAIL a5_even_par: observed len %0d expected len 11 parity 0", obs.size());
    end
    n_assert++;
    assert (busy_cnt === 11) else begin
      n_fail++;
      $error("FAIL a5_even_busy: observed %0d expected 11", busy_cnt);
    end

    // 0xA5 odd parity.
    send_frame(8'hA5, 1'b1, 1'b1, "a5_odd");
    n_assert++;
    assert (obs.size() == 11 && obs[9] === 1'b1) else begin
      n_fail++;
      $error("FAIL a5_odd_par: observed len %0d expected len 11 parity 1", obs.size());
    end
    n_assert++;
    assert (busy_cnt === 11) else begin
      n_fail++;
      $error("FAIL a5_odd_busy: observed %0d expected 11", busy_cnt);
    end

    // 0xFF odd parity.
    send_frame(8'hFF, 1'b1, 1'b1, "ff_odd");
    seq = pack_obs();
    n_assert++;
    assert (seq === 16'h07FE) else begin
      n_fail++;
      $error("FAIL ff_odd_seq: observed %h expected 07fe", seq);
    end

    // Back-to-back: Data_Valid held high, inputs change every cycle.
    bus.Data_Valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      tick("b2b");
    end
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 14; i++) tick("b2b_drain");

    // Reset during data bit 3 of a 0x00 frame.
    bus.P_DATA = 8'h00;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.Data_Valid = 1'b1;
    tick("mid_start");
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 4; i++) tick("mid_data");
    n_assert++;
    assert (bus.busy === 1'b1 && bus.TX_OUT === 1'b0) else begin
      n_fail++;
      $error("FAIL mid_bit3: observed tx %b busy %b expected tx 0 busy 1", bus.TX_OUT, bus.busy);
    end
    #2 RST = 1'b1;
    #1;
    mq.delete();
    m_tx   = 1'b1;
    m_busy = 1'b0;
    check_line("mid_reset_async");
    tick("mid_reset_hold");
    RST = 1'b0;
    tick("mid_reset_idle");

    send_frame(8'h3C, 1'b0, 1'b0, "post_reset_3c");
    seq = pack_obs();
    n_assert++;
    assert (seq === 16'h0278) else begin
      n_fail++;
      $error("FAIL post_reset_3c_seq: observed %h expected 0278", seq);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.Data_Valid = ($urandom_range(0, 99) < 30);
      randomize_inputs();
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
